// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel push-button conditioner.
package debounce_pkg;

    // Per-channel button state as seen by the auto-repeat logic.
    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        HELD     = 2'd1,
        REPEAT   = 2'd2
    } btn_state_t;

    // Bits needed to hold the larger of two counts, inclusive of the value itself.
    function automatic int count_width(input int a, input int b);
        int m;
        if (a > b) begin
            m = a;
        end else begin
            m = b;
        end
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, stable-cycle debounce counter,
// press/release edge pulses and an auto-repeat FSM.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 50000,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic push_raw,
    input  logic repeat_en,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int CNT_W  = count_width(STABLE_CYCLES, STABLE_CYCLES);
    localparam int HOLD_W = count_width(REPEAT_DELAY, REPEAT_PERIOD);

    localparam logic [CNT_W-1:0]  CNT_ZERO    = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO   = HOLD_W'(1'b0);
    localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1'b1);
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

    // Synchroniser and debounce state
    logic              s1_r;
    logic              s2_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              level_r;
    logic              rise_s;
    logic              fall_s;

    // Auto-repeat state
    logic              en_r;
    btn_state_t        state_r;
    btn_state_t        state_nxt_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_nxt_s;
    logic              fire_s;

    // Registered event pulses
    logic              press_r;
    logic              release_r;
    logic              repeat_r;

    // Two-flop synchroniser for the asynchronous raw button level.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= push_raw;
            s2_r <= s1_r;
        end
    end

    // Debounce decision: count consecutive mismatches, flip level on the last one.
    always_comb begin
        cnt_nxt_s = cnt_r;
        rise_s    = 1'b0;
        fall_s    = 1'b0;
        if (s2_r == level_r) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
            cnt_nxt_s = CNT_ZERO;
            rise_s    = s2_r;
            fall_s    = ~s2_r;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
    end

    // Debounce counter and debounced level register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= CNT_ZERO;
            level_r <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            if (rise_s) begin
                level_r <= 1'b1;
            end else if (fall_s) begin
                level_r <= 1'b0;
            end else begin
                level_r <= level_r;
            end
        end
    end

    // Registered copy of repeat_en so the repeat delay counts from the edge it is sampled high.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_r <= 1'b0;
        end else begin
            en_r <= repeat_en;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RELEASED;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; a level fall always wins over repeat progress.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RELEASED: begin
                if (rise_s) begin
                    state_nxt_s = HELD;
                end else begin
                    state_nxt_s = RELEASED;
                end
            end
            HELD: begin
                if (fall_s) begin
                    state_nxt_s = RELEASED;
                end else if (en_r && (hold_cnt_r == DELAY_LAST)) begin
                    state_nxt_s = REPEAT;
                end else begin
                    state_nxt_s = HELD;
                end
            end
            REPEAT: begin
                if (fall_s) begin
                    state_nxt_s = RELEASED;
                end else if (!en_r) begin
                    state_nxt_s = HELD;
                end else begin
                    state_nxt_s = REPEAT;
                end
            end
            default: begin
                state_nxt_s = RELEASED;
            end
        endcase
    end

    // FSM outputs: hold counter update and repeat fire, cleared on every pulse and transition.
    always_comb begin
        hold_cnt_nxt_s = HOLD_ZERO;
        fire_s         = 1'b0;
        case (state_r)
            RELEASED: begin
                hold_cnt_nxt_s = HOLD_ZERO;
            end
            HELD: begin
                if (fall_s || !en_r) begin
                    hold_cnt_nxt_s = HOLD_ZERO;
                end else if (hold_cnt_r == DELAY_LAST) begin
                    hold_cnt_nxt_s = HOLD_ZERO;
                    fire_s         = 1'b1;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + HOLD_ONE;
                end
            end
            REPEAT: begin
                if (fall_s || !en_r) begin
                    hold_cnt_nxt_s = HOLD_ZERO;
                end else if (hold_cnt_r == PERIOD_LAST) begin
                    hold_cnt_nxt_s = HOLD_ZERO;
                    fire_s         = 1'b1;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + HOLD_ONE;
                end
            end
            default: begin
                hold_cnt_nxt_s = HOLD_ZERO;
            end
        endcase
    end

    // Hold counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_r <= HOLD_ZERO;
        end else begin
            hold_cnt_r <= hold_cnt_nxt_s;
        end
    end

    // Event pulse registers, each high for exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            press_r   <= 1'b0;
            release_r <= 1'b0;
            repeat_r  <= 1'b0;
        end else begin
            press_r   <= rise_s;
            release_r <= fall_s;
            repeat_r  <= fire_s;
        end
    end

    assign level         = level_r;
    assign press_pulse   = press_r;
    assign release_pulse = release_r;
    assign repeat_pulse  = repeat_r;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel push-button conditioner: N_CH independent debounce channels.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int N_CH          = 5,
    parameter int STABLE_CYCLES = 50000,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] push_raw,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] repeat_pulse
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_channel (
            .clk           (clk),
            .rst           (rst),
            .push_raw      (push_raw[i]),
            .repeat_en     (repeat_en[i]),
            .level         (level[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed self-checking bench for debounce_multi (N_CH=2, STABLE=4, DELAY=10, PERIOD=3).
module tb_debounce_multi;

    localparam int N_CH          = 2;
    localparam int STABLE_CYCLES = 4;
    localparam int REPEAT_DELAY  = 10;
    localparam int REPEAT_PERIOD = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] push_raw;
    logic [N_CH-1:0] repeat_en;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press_pulse;
    logic [N_CH-1:0] release_pulse;
    logic [N_CH-1:0] repeat_pulse;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debounce_multi #(
        .N_CH          (N_CH),
        .STABLE_CYCLES (STABLE_CYCLES),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .push_raw      (push_raw),
        .repeat_en     (repeat_en),
        .level         (level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    // Advance past one rising edge; sample and drive 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int t, input logic [1:0] lv,
                             input logic [1:0] pr, input logic [1:0] rl, input logic [1:0] rp);
        check($sformatf("%s t=%0d level", tag, t), level, lv);
        check($sformatf("%s t=%0d press", tag, t), press_pulse, pr);
        check($sformatf("%s t=%0d release", tag, t), release_pulse, rl);
        check($sformatf("%s t=%0d repeat", tag, t), repeat_pulse, rp);
    endtask

    initial begin
        logic [1:0] lv;
        rst       = 1'b1;
        push_raw  = 2'b00;
        repeat_en = 2'b00;

        // Reset state
        tick();
        tick();
        check_all("reset", 0, 2'b00, 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        tick();
        tick();
        check_all("idle", 0, 2'b00, 2'b00, 2'b00, 2'b00);

        // 1. Clean press on channel 0, held 20 cycles, then release
        push_raw = 2'b01;
        for (int t = 1; t <= 20; t++) begin
            tick();
            check_all("press", t, (t >= 6) ? 2'b01 : 2'b00, (t == 6) ? 2'b01 : 2'b00, 2'b00, 2'b00);
        end
        push_raw = 2'b00;
        for (int t = 1; t <= 8; t++) begin
            tick();
            check_all("release", t, (t >= 6) ? 2'b00 : 2'b01, 2'b00, (t == 6) ? 2'b01 : 2'b00, 2'b00);
        end

        // 2. Glitch rejection: high 3, low 1, high 3, low
        for (int t = 1; t <= 18; t++) begin
            push_raw = ((t <= 3) || (t >= 5 && t <= 7)) ? 2'b01 : 2'b00;
            tick();
            check_all("glitch", t, 2'b00, 2'b00, 2'b00, 2'b00);
        end
        push_raw = 2'b00;

        // 3. Auto-repeat: level rises at t=6, repeats at 16/19/22; release edge 25 suppresses the due repeat
        repeat_en = 2'b01;
        push_raw  = 2'b01;
        for (int t = 1; t <= 32; t++) begin
            tick();
            check_all("autorep", t, (t >= 6 && t < 25) ? 2'b01 : 2'b00,
                      (t == 6) ? 2'b01 : 2'b00, (t == 25) ? 2'b01 : 2'b00,
                      (t == 16 || t == 19 || t == 22) ? 2'b01 : 2'b00);
            if (t == 19) begin
                push_raw = 2'b00;
            end
        end
        repeat_en = 2'b00;

        // 4. repeat_en control: 30 cycles held without repeat, enable sampled at edge 37 -> repeats 47, 50;
        //    enable dropped after 51 stops the pulse due at 53
        push_raw = 2'b01;
        for (int t = 1; t <= 68; t++) begin
            tick();
            check_all("rep_en", t, (t >= 6 && t < 66) ? 2'b01 : 2'b00,
                      (t == 6) ? 2'b01 : 2'b00, (t == 66) ? 2'b01 : 2'b00,
                      (t == 47 || t == 50) ? 2'b01 : 2'b00);
            if (t == 36) begin
                repeat_en = 2'b01;
            end
            if (t == 51) begin
                repeat_en = 2'b00;
            end
            if (t == 60) begin
                push_raw = 2'b00;
            end
        end

        // 5. Reset mid-hold while in REPEAT
        repeat_en = 2'b01;
        push_raw  = 2'b01;
        for (int t = 1; t <= 17; t++) begin
            tick();
        end
        check("pre_rst level", level, 2'b01);
        rst = 1'b1;
        tick();
        check_all("rst_hold", 1, 2'b00, 2'b00, 2'b00, 2'b00);
        tick();
        check_all("rst_hold", 2, 2'b00, 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            tick();
            check("post_rst level", level, (t >= 6) ? 2'b01 : 2'b00);
            check("post_rst press", press_pulse, (t == 6) ? 2'b01 : 2'b00);
        end
        push_raw  = 2'b00;
        repeat_en = 2'b00;
        for (int t = 1; t <= 10; t++) begin
            tick();
        end
        check("post_rst settled", level, 2'b00);

        // 6. Simultaneous press on both channels, staggered releases
        push_raw = 2'b11;
        for (int t = 1; t <= 18; t++) begin
            tick();
            lv = {(t >= 6 && t < 16), (t >= 6 && t < 14)};
            check_all("dual", t, lv, (t == 6) ? 2'b11 : 2'b00,
                      (t == 14) ? 2'b01 : ((t == 16) ? 2'b10 : 2'b00), 2'b00);
            if (t == 8) begin
                push_raw = 2'b10;
            end
            if (t == 10) begin
                push_raw = 2'b00;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
